// File: rtl/lock_sequencer.sv
// rtl/lock_sequencer.sv - two-button serial code lock sequencer
// Collects CODE_LEN-digit attempts, checks them against a programmable code, and times unlock, lockout and idle.
module lock_sequencer #(
  parameter int                  CODE_LEN       = 5,
  parameter logic [CODE_LEN-1:0] RESET_CODE     = 5'b01011,
  parameter int                  MAX_FAIL       = 3,
  parameter int                  LOCKOUT_CYCLES = 16,
  parameter int                  UNLOCK_CYCLES  = 8,
  parameter int                  TIMEOUT_CYCLES = 32,
  localparam int                 FW             = $clog2(MAX_FAIL + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          button0,
  input  logic          button1,
  input  logic          prog_en,
  output logic          unlock,
  output logic          lockout,
  output logic [FW-1:0] fail_cnt,
  output logic          entry_active,
  output logic          code_updated
);

  localparam int CW   = $clog2(CODE_LEN + 1);
  localparam int TMAX = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int OW   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0] LAST_IDX    = CW'(CODE_LEN - 1);
  localparam logic [FW-1:0] MAX_F       = FW'(MAX_FAIL);
  localparam logic [TW-1:0] UNLOCK_LOAD = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD   = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [OW-1:0] TO_LOAD     = OW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ENTRY   = 3'd1;
  localparam logic [2:0] S_OPEN    = 3'd2;
  localparam logic [2:0] S_PROG    = 3'd3;
  localparam logic [2:0] S_LOCKOUT = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CODE_LEN-1:0] shreg_q, shreg_d;
  logic [CODE_LEN-1:0] code_q, code_d;
  logic [FW-1:0]       fail_q, fail_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [OW-1:0]       to_q, to_d;
  logic                upd_q, upd_d;

  logic                digit_v;
  logic                abort;
  logic [CODE_LEN-1:0] cand;
  logic [FW-1:0]       fail_inc;

  assign digit_v = button0 ^ button1;
  assign abort   = button0 & button1;

  always_comb begin
    cand = shreg_q;
    for (int k = 0; k < CODE_LEN; k++) begin
      if (k == int'(cnt_q)) cand[k] = button1;
    end
    fail_inc = (fail_q == MAX_F) ? fail_q : fail_q + FW'(1);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    code_d  = code_q;
    fail_d  = fail_q;
    tmr_d   = tmr_q;
    to_d    = to_q;
    upd_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (digit_v) begin
          state_d = S_ENTRY;
          shreg_d = CODE_LEN'(button1);
          cnt_d   = CW'(1);
          to_d    = TO_LOAD;
        end
      end
      S_ENTRY, S_PROG: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          shreg_d = '0;
        end else if (digit_v) begin
          to_d = TO_LOAD;
          if (cnt_q == LAST_IDX) begin
            // Final digit closes the attempt; the register is cleared so it cannot seed the next one.
            cnt_d   = '0;
            shreg_d = '0;
            if (state_q == S_PROG) begin
              code_d  = cand;
              upd_d   = 1'b1;
              state_d = S_IDLE;
            end else if (cand == code_q) begin
              state_d = S_OPEN;
              fail_d  = '0;
              tmr_d   = UNLOCK_LOAD;
            end else begin
              fail_d = fail_inc;
              if (fail_inc == MAX_F) begin
                state_d = S_LOCKOUT;
                tmr_d   = LOCK_LOAD;
              end else begin
                state_d = S_IDLE;
              end
            end
          end else begin
            shreg_d = cand;
            cnt_d   = cnt_q + CW'(1);
          end
        end else if (to_q == '0) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          shreg_d = '0;
        end else begin
          to_d = to_q - OW'(1);
        end
      end
      S_OPEN: begin
        if (prog_en) begin
          state_d = S_PROG;
          to_d    = TO_LOAD;
          cnt_d   = '0;
          shreg_d = '0;
        end else if (tmr_q == '0) begin
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_LOCKOUT: begin
        if (tmr_q == '0) begin
          state_d = S_IDLE;
          fail_d  = '0;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        shreg_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      code_q  <= RESET_CODE;
      fail_q  <= '0;
      tmr_q   <= '0;
      to_q    <= '0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      code_q  <= code_d;
      fail_q  <= fail_d;
      tmr_q   <= tmr_d;
      to_q    <= to_d;
      upd_q   <= upd_d;
    end
  end

  assign unlock       = (state_q == S_OPEN) || (state_q == S_PROG);
  assign lockout      = (state_q == S_LOCKOUT);
  assign entry_active = (state_q == S_ENTRY) || (state_q == S_PROG);
  assign fail_cnt     = fail_q;
  assign code_updated = upd_q;

endmodule
